// File: rtl/cache_stage_if.sv
// Memory-side request/acknowledge bus between cache_stage and the memory system.
// Latency: none; this is wiring only.
// Backpressure: the master holds req/we/addr/wdata stable until the slave returns ack.
interface cache_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_stage.sv
// Memory-access stage: direct-mapped, write-through, no-write-allocate data cache.
// Latency: hits and non-memory ops complete combinationally in the cycle after capture; misses and stores wait for mem_ack.
// Backpressure: stall_cache is high while a miss or store is outstanding; upstream must hold enable_cache low.
module cache_stage #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_cache,
  input  logic [15:0] tlblookup_result,
  input  logic [15:0] dataReg,
  input  logic [1:0]  ldSt_enable,
  input  logic [2:0]  destReg_addr_input,
  input  logic        we_input,
  input  logic [1:0]  bp_input,
  input  logic [2:0]  tail_rob_input,
  output logic [15:0] cache_result,
  output logic [2:0]  destReg_addr_output,
  output logic [2:0]  destReg_addrCACHE,
  output logic        cache_bypass_valid,
  output logic        we_output,
  output logic [1:0]  bp_output,
  output logic [2:0]  tail_rob_output,
  output logic        stall_cache,
  cache_stage_if.master mem
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 15 - INDEX_BITS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RDMISS = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  // Captured stage inputs
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  op_q;
  logic [2:0]  dest_q;
  logic        we_q;
  logic [1:0]  bp_q;
  logic [2:0]  tail_q;
  logic        pending_q;
  logic [15:0] ld_data_q;
  logic [1:0]  state_q;
  logic [1:0]  state_d;

  // Cache storage; only valid needs a reset
  logic [15:0]         data_arr [LINES];
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [LINES-1:0]    valid_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  is_load;
  logic                  is_store;
  logic                  hit;
  logic                  done;
  logic                  fill;
  logic                  upd;
  logic [15:0]           result;

  assign idx      = addr_q[INDEX_BITS:1];
  assign tag      = addr_q[15:INDEX_BITS+1];
  assign is_load  = (op_q == 2'b10);
  assign is_store = (op_q == 2'b01);
  assign hit      = valid_q[idx] && (tag_arr[idx] == tag);

  // Next-state, stall and result selection for the captured operation
  always_comb begin
    state_d     = state_q;
    stall_cache = 1'b0;
    done        = 1'b0;
    fill        = 1'b0;
    upd         = 1'b0;
    // A finished load keeps presenting its data while the register holds it
    result      = (is_load && !pending_q) ? ld_data_q : addr_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          if (is_load) begin
            if (hit) begin
              result = data_arr[idx];
              done   = 1'b1;
            end else begin
              stall_cache = 1'b1;
              state_d     = ST_RDMISS;
            end
          end else if (is_store) begin
            stall_cache = 1'b1;
            upd         = hit;
            state_d     = ST_WRITE;
          end
        end
      end
      ST_RDMISS: begin
        if (mem.mem_ack) begin
          result  = mem.mem_rdata;
          fill    = 1'b1;
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_cache = 1'b1;
        end
      end
      ST_WRITE: begin
        if (mem.mem_ack) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_cache = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Input register, pending flag, FSM state and line-valid bits
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      we_q      <= 1'b0;
      bp_q      <= '0;
      tail_q    <= '0;
      pending_q <= 1'b0;
      ld_data_q <= '0;
      state_q   <= ST_IDLE;
      valid_q   <= '0;
    end else begin
      if (enable_cache) begin
        addr_q    <= tlblookup_result;
        wdata_q   <= dataReg;
        op_q      <= ldSt_enable;
        dest_q    <= destReg_addr_input;
        we_q      <= we_input;
        bp_q      <= bp_input;
        tail_q    <= tail_rob_input;
        pending_q <= (ldSt_enable == 2'b10) || (ldSt_enable == 2'b01);
      end else if (done) begin
        pending_q <= 1'b0;
      end
      if (done && is_load) begin
        ld_data_q <= result;
      end
      if (fill) begin
        valid_q[idx] <= 1'b1;
      end
      state_q <= state_d;
    end
  end

  // Line data/tag: refill on read ack, write-through update on store hit
  always_ff @(posedge clk) begin
    if (fill) begin
      data_arr[idx] <= mem.mem_rdata;
      tag_arr[idx]  <= tag;
    end else if (upd) begin
      data_arr[idx] <= wdata_q;
    end
  end

  assign cache_result        = result;
  assign destReg_addr_output = dest_q;
  assign destReg_addrCACHE   = dest_q;
  assign we_output           = we_q;
  assign bp_output           = bp_q;
  assign tail_rob_output     = tail_q;
  assign cache_bypass_valid  = we_q & ~stall_cache;

  // Request fields come straight from the held input register, so they stay stable
  assign mem.mem_req   = (state_q != ST_IDLE);
  assign mem.mem_we    = (state_q == ST_WRITE);
  assign mem.mem_addr  = {addr_q[15:1], 1'b0};
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_cache_stage.sv
// Bench for cache_stage: directed scenarios then random ops against a line-level cache model.
// Latency: checks completion cycle, request count and stall count per op.
// Backpressure: memory responder acks after a chosen number of request cycles.
module tb_cache_stage;
  logic        clk;
  logic        reset;
  logic        enable_cache;
  logic [15:0] tlblookup_result;
  logic [15:0] dataReg;
  logic [1:0]  ldSt_enable;
  logic [2:0]  destReg_addr_input;
  logic        we_input;
  logic [1:0]  bp_input;
  logic [2:0]  tail_rob_input;
  logic [15:0] cache_result;
  logic [2:0]  destReg_addr_output;
  logic [2:0]  destReg_addrCACHE;
  logic        cache_bypass_valid;
  logic        we_output;
  logic [1:0]  bp_output;
  logic [2:0]  tail_rob_output;
  logic        stall_cache;

  cache_stage_if m ();

  cache_stage #(.INDEX_BITS(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable_cache        (enable_cache),
    .tlblookup_result    (tlblookup_result),
    .dataReg             (dataReg),
    .ldSt_enable         (ldSt_enable),
    .destReg_addr_input  (destReg_addr_input),
    .we_input            (we_input),
    .bp_input            (bp_input),
    .tail_rob_input      (tail_rob_input),
    .cache_result        (cache_result),
    .destReg_addr_output (destReg_addr_output),
    .destReg_addrCACHE   (destReg_addrCACHE),
    .cache_bypass_valid  (cache_bypass_valid),
    .we_output           (we_output),
    .bp_output           (bp_output),
    .tail_rob_output     (tail_rob_output),
    .stall_cache         (stall_cache),
    .mem                 (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: external memory image and cache lines
  logic [15:0] ext_mem [int];
  logic [15:0] ref_mem [int];
  bit          ref_valid [16];
  int          ref_tag   [16];
  logic [15:0] ref_data  [16];

  function automatic logic [15:0] seed_val(input int word);
    return 16'((word * 40503) ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ext_rd(input int word);
    if (ext_mem.exists(word)) return ext_mem[word];
    return seed_val(word);
  endfunction

  function automatic logic [15:0] ref_rd(input int word);
    if (ref_mem.exists(word)) return ref_mem[word];
    return seed_val(word);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [2:0] dest, input logic we, input int delay);
    int          word, idx, tg, nreq, nstall;
    bit          hit, is_ld, is_st, done;
    logic [15:0] exp_res;
    int          exp_req, exp_stall;
    logic [1:0]  bp;
    logic [2:0]  tail;
    is_ld = (op == 2'b10);
    is_st = (op == 2'b01);
    word  = int'(addr) >> 1;
    idx   = word % 16;
    tg    = int'(addr) >> 5;
    hit   = ref_valid[idx] && (ref_tag[idx] == tg);
    bp    = 2'($urandom);
    tail  = 3'($urandom);
    if (is_ld) begin
      if (hit) begin
        exp_res = ref_data[idx]; exp_req = 0; exp_stall = 0;
      end else begin
        exp_res = ref_rd(word); exp_req = delay + 1; exp_stall = delay + 1;
        ref_valid[idx] = 1'b1; ref_tag[idx] = tg; ref_data[idx] = exp_res;
      end
    end else if (is_st) begin
      exp_res = addr; exp_req = delay + 1; exp_stall = delay + 1;
      ref_mem[word] = wd;
      if (hit) ref_data[idx] = wd;
    end else begin
      exp_res = addr; exp_req = 0; exp_stall = 0;
    end

    // The previous op has completed; it must not re-issue while held
    @(negedge clk);
    chk("held_req", 32'(m.mem_req), 32'd0);
    chk("held_stall", 32'(stall_cache), 32'd0);
    tlblookup_result   = addr;
    dataReg            = wd;
    ldSt_enable        = op;
    destReg_addr_input = dest;
    we_input           = we;
    bp_input           = bp;
    tail_rob_input     = tail;
    enable_cache       = 1'b1;
    @(posedge clk);
    #1;
    enable_cache       = 1'b0;
    tlblookup_result   = 16'($urandom);
    dataReg            = 16'($urandom);
    ldSt_enable        = 2'($urandom);
    destReg_addr_input = 3'($urandom);
    we_input           = 1'($urandom);

    nreq = 0; nstall = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (m.mem_req) begin
        chk("mem_addr", 32'(m.mem_addr), 32'({addr[15:1], 1'b0}));
        chk("mem_we", 32'(m.mem_we), 32'(is_st));
        if (is_st) chk("mem_wdata", 32'(m.mem_wdata), 32'(wd));
        if (nreq == delay) begin
          m.mem_ack = 1'b1;
          if (m.mem_we) ext_mem[int'(m.mem_addr) >> 1] = m.mem_wdata;
          else m.mem_rdata = ext_rd(int'(m.mem_addr) >> 1);
        end
        nreq++;
      end
      #1;
      if (!stall_cache) begin
        done = 1'b1;
        chk("cache_result", 32'(cache_result), 32'(exp_res));
        chk("dest_out", 32'(destReg_addr_output), 32'(dest));
        chk("dest_cache", 32'(destReg_addrCACHE), 32'(dest));
        chk("we_out", 32'(we_output), 32'(we));
        chk("bypass_valid", 32'(cache_bypass_valid), 32'(we));
        chk("bp_out", 32'(bp_output), 32'(bp));
        chk("tail_out", 32'(tail_rob_output), 32'(tail));
      end else begin
        nstall++;
        chk("bypass_stalled", 32'(cache_bypass_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      m.mem_ack   = 1'b0;
      m.mem_rdata = 16'($urandom);
    end
    if (!done) chk("op_timeout", 32'd0, 32'd1);
    chk("req_cycles", 32'(nreq), 32'(exp_req));
    chk("stall_cycles", 32'(nstall), 32'(exp_stall));
  endtask

  initial begin
    int seen;
    reset = 1'b1; enable_cache = 1'b0;
    tlblookup_result = '0; dataReg = '0; ldSt_enable = '0;
    destReg_addr_input = '0; we_input = 1'b0; bp_input = '0; tail_rob_input = '0;
    m.mem_ack = 1'b0; m.mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0; ref_tag[i] = 0; ref_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stall_cache), 32'd0);
    chk("rst_req", 32'(m.mem_req), 32'd0);
    chk("rst_we_out", 32'(we_output), 32'd0);
    chk("rst_result", 32'(cache_result), 32'd0);
    chk("rst_bypass", 32'(cache_bypass_valid), 32'd0);

    // Miss with delayed ack, then hit
    ext_mem[8] = 16'hBEEF;
    ref_mem[8] = 16'hBEEF;
    run_op(2'b10, 16'h0010, 16'h0000, 3'd1, 1'b1, 2);
    run_op(2'b10, 16'h0010, 16'h0000, 3'd2, 1'b1, 0);
    // Store hit updates the line; load hits new data
    run_op(2'b01, 16'h0010, 16'h1234, 3'd0, 1'b0, 1);
    run_op(2'b10, 16'h0010, 16'h0000, 3'd4, 1'b1, 0);
    // Store to same index, other tag leaves the line alone
    run_op(2'b01, 16'h0210, 16'h5555, 3'd0, 1'b0, 0);
    run_op(2'b10, 16'h0010, 16'h0000, 3'd5, 1'b1, 0);
    // Plain ALU result
    run_op(2'b00, 16'h00A5, 16'h0000, 3'd3, 1'b1, 0);

    // Reset during an outstanding read miss
    @(negedge clk);
    tlblookup_result = 16'h7770; ldSt_enable = 2'b10; we_input = 1'b1;
    destReg_addr_input = 3'd6; enable_cache = 1'b1;
    @(posedge clk);
    #1 enable_cache = 1'b0; ldSt_enable = 2'b00;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (m.mem_req) seen = 1;
    end
    chk("miss_req_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_drop_req", 32'(m.mem_req), 32'd0);
    chk("rst_drop_stall", 32'(stall_cache), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    run_op(2'b10, 16'h7770, 16'h0000, 3'd6, 1'b1, 1);

    // Random mix over a small address pool to force hits and conflicts
    for (int n = 0; n < 300; n++) begin
      int r, t, ix;
      logic [1:0]  op;
      logic [15:0] a;
      r  = $urandom_range(0, 9);
      t  = $urandom_range(0, 3);
      ix = $urandom_range(0, 7);
      a  = 16'((t << 5) | (ix << 1) | $urandom_range(0, 1));
      if (r < 4)      op = 2'b10;
      else if (r < 7) op = 2'b01;
      else if (r < 9) op = 2'b00;
      else            op = 2'b11;
      run_op(op, a, 16'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
